ssp_rx: RTL and testbench

- Receive half of the SSP serial port.
- Deserializes the external frame stream (SSPCLKIN, SSPFSSIN, SSPRXD) into 8-bit words and pushes them into the receive FIFO with a single-cycle strobe.
- Line format is the one our SSP transmitter drives:
  - FSS is high for one serial-clock period immediately before the MSB period.
  - Back-to-back frames overlap FSS with the previous word's LSB period.
  - Data is MSB first and changes on the SSPCLK rising edge.
- This block samples on the SSPCLKIN falling edge, oversampled in the PCLK domain.

---
 rtl/ssp_pkg.sv | 17 +
 rtl/ssp_rx_if.sv | 23 ++
 rtl/ssp_sync.sv | 34 +++
 rtl/ssp_rx.sv | 132 +++++++++++++
 tb/tb_ssp_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ssp_pkg.sv
// Shared constants and types for the SSP receive path.
package ssp_pkg;

   localparam int RX_DATA_WIDTH = 8;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_e;

   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

   localparam int RX_CNT_W = cnt_width(RX_DATA_WIDTH);

endpackage

// File: rtl/ssp_rx_if.sv
// Receive-FIFO side of the SSP receiver: write strobe, word and status pulses.
interface ssp_rx_if
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = RX_DATA_WIDTH
);
   logic                  RxIsFull;
   logic [DATA_WIDTH-1:0] RxData;
   logic                  RxNextWord;
   logic                  RxOverrun;
   logic                  RxFrameErr;
   logic                  RxBusy;

   modport master (
      input  RxIsFull,
      output RxData, RxNextWord, RxOverrun, RxFrameErr, RxBusy
   );

   modport slave (
      output RxIsFull,
      input  RxData, RxNextWord, RxOverrun, RxFrameErr, RxBusy
   );
endinterface

// File: rtl/ssp_sync.sv
// Multi-stage synchronizer; all bits share the same depth so they stay aligned.
module ssp_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/ssp_rx.sv
// SSP receiver: oversamples the serial line in PCLK, deserializes MSB-first
// frames and writes completed words to the receive FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RX_IDLE  | waiting for FSS on a serial-clock falling edge
//   RX_SHIFT | collecting bits; cnt_q is the number of bits still to come
module ssp_rx
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH  = RX_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic     PCLK,
   input  logic     CLEAR_B,
   input  logic     SSPCLKIN,
   input  logic     SSPFSSIN,
   input  logic     SSPRXD,
   ssp_rx_if.master fifo
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [2:0] sync_out;
   logic       sclk_s, fss_s, rxd_s;
   logic       samp;

   ssp_sync #(
      .WIDTH  (3),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (PCLK),
      .rst_n (CLEAR_B),
      .din   ({SSPCLKIN, SSPFSSIN, SSPRXD}),
      .dout  (sync_out)
   );

   assign {sclk_s, fss_s, rxd_s} = sync_out;

   rx_state_e             state_q, state_d;
   logic                  sclk_prev_q, sclk_prev_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-2:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  next_q, next_d;
   logic                  ovr_q, ovr_d;
   logic                  ferr_q, ferr_d;
   logic [DATA_WIDTH-1:0] word;

   // Falling edge of the synced serial clock: one PCLK per serial period.
   assign samp = sclk_prev_q & ~sclk_s;
   assign word = {shift_q, rxd_s};

   always_comb begin
      state_d     = state_q;
      sclk_prev_d = sclk_s;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      next_d      = 1'b0;
      ovr_d       = 1'b0;
      ferr_d      = 1'b0;
      if (samp) begin
         case (state_q)
            RX_IDLE: begin
               if (fss_s) begin
                  state_d = RX_SHIFT;
                  cnt_d   = CNT_LAST;
                  shift_d = '0;
               end
            end
            RX_SHIFT: begin
               if (cnt_q != '0) begin
                  if (fss_s) begin
                     ferr_d  = 1'b1;
                     shift_d = '0;
                     cnt_d   = CNT_LAST;
                  end else begin
                     shift_d = word[DATA_WIDTH-2:0];
                     cnt_d   = cnt_q - CNT_W'(1);
                  end
               end else begin
                  if (!fifo.RxIsFull) begin
                     data_d = word;
                     next_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
                  // FSS overlapping the LSB starts the next frame with no gap.
                  shift_d = '0;
                  if (fss_s) begin
                     cnt_d = CNT_LAST;
                  end else begin
                     state_d = RX_IDLE;
                  end
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         state_q     <= RX_IDLE;
         sclk_prev_q <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         next_q      <= 1'b0;
         ovr_q       <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_prev_q <= sclk_prev_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         next_q      <= next_d;
         ovr_q       <= ovr_d;
         ferr_q      <= ferr_d;
      end
   end

   assign fifo.RxData     = data_q;
   assign fifo.RxNextWord = next_q;
   assign fifo.RxOverrun  = ovr_q;
   assign fifo.RxFrameErr = ferr_q;
   assign fifo.RxBusy     = (state_q == RX_SHIFT);

endmodule

// File: tb/tb_ssp_rx.sv
// Directed bench for ssp_rx: drives framed serial words at PCLK/12 and
// checks strobes, status pulses and received data.
module tb_ssp_rx;

   logic PCLK;
   logic CLEAR_B;
   logic SSPCLKIN;
   logic SSPFSSIN;
   logic SSPRXD;

   ssp_rx_if fifo_if ();

   ssp_rx dut (
      .PCLK     (PCLK),
      .CLEAR_B  (CLEAR_B),
      .SSPCLKIN (SSPCLKIN),
      .SSPFSSIN (SSPFSSIN),
      .SSPRXD   (SSPRXD),
      .fifo     (fifo_if)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int n_tests = 0;
   int n_fail  = 0;

   int         nw_cnt    = 0;
   int         ovr_cnt   = 0;
   int         ferr_cnt  = 0;
   int         busy_fall = 0;
   int         busy_hi   = 0;
   logic       busy_prev = 1'b0;
   logic [7:0] words [$];
   longint     nw_times [$];

   always @(negedge PCLK) begin
      if (fifo_if.RxNextWord) begin
         nw_cnt++;
         words.push_back(fifo_if.RxData);
         nw_times.push_back($time);
      end
      if (fifo_if.RxOverrun)  ovr_cnt++;
      if (fifo_if.RxFrameErr) ferr_cnt++;
      if (busy_prev && !fifo_if.RxBusy) busy_fall++;
      if (fifo_if.RxBusy) busy_hi++;
      busy_prev = fifo_if.RxBusy;
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One serial period: data changes on the rising edge, sampled on the fall.
   task automatic send_bit(input logic fss, input logic rxd);
      SSPCLKIN = 1'b1;
      SSPFSSIN = fss;
      SSPRXD   = rxd;
      #60;
      SSPCLKIN = 1'b0;
      #60;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic last_fss);
      send_bit(1'b1, 1'b0);
      for (int i = 7; i >= 1; i--) send_bit(1'b0, d[i]);
      send_bit(last_fss, d[0]);
   endtask

   task automatic idle(input int n);
      repeat (n) send_bit(1'b0, 1'b0);
   endtask

   int         nw0, ovr0, ferr0, bf0, bh0;
   logic       seen;
   logic [7:0] a5;
   longint     dt;

   initial begin
      CLEAR_B  = 1'b0;
      SSPCLKIN = 1'b0;
      SSPFSSIN = 1'b0;
      SSPRXD   = 1'b0;
      fifo_if.RxIsFull = 1'b0;
      #23;
      check_val("rst_data", fifo_if.RxData, 8'h00);
      check_val("rst_flags", {fifo_if.RxNextWord, fifo_if.RxOverrun,
                              fifo_if.RxFrameErr, fifo_if.RxBusy}, 4'b0000);
      #10;
      CLEAR_B = 1'b1;
      #40;

      // 0xA5 with latency check on the last falling edge
      nw0 = nw_cnt;
      a5  = 8'hA5;
      send_bit(1'b1, 1'b0);
      for (int i = 7; i >= 1; i--) send_bit(1'b0, a5[i]);
      SSPCLKIN = 1'b1;
      SSPFSSIN = 1'b0;
      SSPRXD   = a5[0];
      #60;
      SSPCLKIN = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge PCLK);
         #1;
         if (fifo_if.RxNextWord) seen = 1'b1;
      end
      check_val("a5_latency", seen, 1'b1);
      #20;
      idle(2);
      check_val("a5_strobes", nw_cnt - nw0, 1);
      check_val("a5_data", fifo_if.RxData, 8'hA5);
      check_val("a5_busy", fifo_if.RxBusy, 1'b0);

      // back-to-back 0x3C, 0xC3
      nw0 = nw_cnt;
      bf0 = busy_fall;
      send_frame(8'h3C, 1'b1);
      for (int i = 7; i >= 1; i--) send_bit(1'b0, 8'hC3 >> i);
      send_bit(1'b0, 1'b1);
      idle(2);
      check_val("b2b_strobes", nw_cnt - nw0, 2);
      if (nw_cnt - nw0 == 2) begin
         check_val("b2b_word0", words[nw0], 8'h3C);
         check_val("b2b_word1", words[nw0+1], 8'hC3);
         dt = nw_times[nw0+1] - nw_times[nw0];
         check_val("b2b_spacing", 32'(dt), 32'd960);
      end
      check_val("b2b_busy_falls", busy_fall - bf0, 1);

      // overrun on 0x5A, then 0x81 received normally
      nw0  = nw_cnt;
      ovr0 = ovr_cnt;
      fifo_if.RxIsFull = 1'b1;
      send_frame(8'h5A, 1'b0);
      idle(1);
      fifo_if.RxIsFull = 1'b0;
      check_val("ovr_strobes", nw_cnt - nw0, 0);
      check_val("ovr_pulses", ovr_cnt - ovr0, 1);
      check_val("ovr_data_held", fifo_if.RxData, 8'hC3);
      send_frame(8'h81, 1'b0);
      idle(2);
      check_val("post_ovr_strobes", nw_cnt - nw0, 1);
      check_val("post_ovr_data", fifo_if.RxData, 8'h81);
      check_val("post_ovr_pulses", ovr_cnt - ovr0, 1);

      // FSS reasserted after 4 bits, then a full 0xF0
      nw0   = nw_cnt;
      ferr0 = ferr_cnt;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_frame(8'hF0, 1'b0);
      idle(2);
      check_val("ferr_pulses", ferr_cnt - ferr0, 1);
      check_val("ferr_strobes", nw_cnt - nw0, 1);
      check_val("ferr_data", fifo_if.RxData, 8'hF0);

      // reset after 5 bits, trailing bits ignored, then 0x99
      nw0 = nw_cnt;
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
      check_val("pre_clr_busy", fifo_if.RxBusy, 1'b1);
      CLEAR_B = 1'b0;
      #1;
      check_val("clr_data", fifo_if.RxData, 8'h00);
      check_val("clr_busy", fifo_if.RxBusy, 1'b0);
      #20;
      CLEAR_B = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
      idle(3);
      check_val("clr_no_strobe", nw_cnt - nw0, 0);
      check_val("clr_idle_busy", fifo_if.RxBusy, 1'b0);
      send_frame(8'h99, 1'b0);
      idle(2);
      check_val("clr_next_strobe", nw_cnt - nw0, 1);
      check_val("clr_next_data", fifo_if.RxData, 8'h99);

      // 20 periods of noise with no FSS
      nw0   = nw_cnt;
      ovr0  = ovr_cnt;
      ferr0 = ferr_cnt;
      bh0   = busy_hi;
      for (int i = 0; i < 20; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
      idle(1);
      check_val("noise_events", (nw_cnt - nw0) + (ovr_cnt - ovr0) + (ferr_cnt - ferr0), 0);
      check_val("noise_busy", busy_hi - bh0, 0);
      check_val("noise_data", fifo_if.RxData, 8'h99);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
